spi_frame_responder: RTL

- Target-side end of the 40-bit single-clock SPI link: samples cs_b/mosi/spi_sel on clk and drives miso back to the initiator.
- Decodes each complete frame into a configuration-register write (spi_sel=0) or a DAC-code write (spi_sel=1).
- Returns the last committed frame on miso during the next transaction, giving loopback readback.
- Sits in the analog-front-end register block, in the same clk domain as the SPI initiator.

---
 rtl/spi_link_pkg.sv | 23 ++
 rtl/spi_shift40.sv | 57 +++++
 rtl/spi_frame_responder.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/spi_link_pkg.sv
// Constants and types shared by both ends of the 40-bit single-clock SPI link.
// The initiator imports this package so frame layout and target codes stay in one place.
package spi_link_pkg;

   localparam int unsigned FRAME_BITS   = 40;
   localparam int unsigned DAC_BITS     = 32;
   localparam int unsigned DAC_PAD_BITS = 8;
   localparam int unsigned CNT_W        = $clog2(FRAME_BITS + 1);

   localparam logic SEL_CFG = 1'b0;
   localparam logic SEL_DAC = 1'b1;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } link_state_e;

   // A DAC frame carries its code in the upper bits; the low pad byte must be zero.
   function automatic logic dac_pad_ok(input logic [FRAME_BITS-1:0] frame);
      return frame[DAC_PAD_BITS-1:0] == '0;
   endfunction

endpackage

// File: rtl/spi_shift40.sv
// Parallel-load, shift-left register with serial in/out and a saturating bit counter.
// Load has priority over shift; the counter stops at W+1 so an overrun stays visible.
module spi_shift40
   import spi_link_pkg::*;
#(
   parameter int unsigned W  = FRAME_BITS,
   parameter int unsigned CW = CNT_W
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic [W-1:0]  load_val,
   input  logic [CW-1:0] load_cnt,
   input  logic          shift,
   input  logic          ser_in,
   input  logic          cnt_clr,
   output logic [W-1:0]  q,
   output logic          ser_out,
   output logic [CW-1:0] cnt
);

   localparam logic [CW-1:0] SAT = CW'(W + 1);

   logic [W-1:0]  q_q, q_d;
   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      q_d   = q_q;
      cnt_d = cnt_q;
      if (load) begin
         q_d   = load_val;
         cnt_d = load_cnt;
      end else if (shift) begin
         q_d = {q_q[W-2:0], ser_in};
         if (cnt_q != SAT) begin
            cnt_d = cnt_q + CW'(1);
         end
      end else if (cnt_clr) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_q   <= '0;
         cnt_q <= '0;
      end else begin
         q_q   <= q_d;
         cnt_q <= cnt_d;
      end
   end

   assign q       = q_q;
   assign ser_out = q_q[W-1];
   assign cnt     = cnt_q;

endmodule

// File: rtl/spi_frame_responder.sv
// Target side of the 40-bit SPI link: decodes config / DAC frames on cs_b rise and
// plays the last committed frame back on miso during the following transaction.
module spi_frame_responder
   import spi_link_pkg::*;
#(
   parameter logic [FRAME_BITS-1:0] CFG_RST = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cs_b,
   input  logic                  mosi,
   input  logic                  spi_sel,
   output logic                  miso,
   output logic [FRAME_BITS-1:0] cfg_reg,
   output logic                  cfg_wr,
   output logic [DAC_BITS-1:0]   dac_code,
   output logic                  dac_wr,
   output logic                  frame_err,
   output logic                  busy
);

   // Frame protocol: while cs_b is low every rising edge moves one bit each way;
   // the first edge with cs_b high after SHIFT is the commit edge, no back-pressure.
   link_state_e           state_q, state_d;
   logic                  sel_q, sel_d;
   logic [FRAME_BITS-1:0] last_frame_q, last_frame_d;
   logic [FRAME_BITS-1:0] cfg_reg_q, cfg_reg_d;
   logic [DAC_BITS-1:0]   dac_code_q, dac_code_d;
   logic                  cfg_wr_q, cfg_wr_d;
   logic                  dac_wr_q, dac_wr_d;
   logic                  frame_err_q, frame_err_d;

   logic [FRAME_BITS-1:0] rx_q;
   logic [CNT_W-1:0]      bit_cnt;
   logic                  rx_ser_unused;

   logic                  tx_load;
   logic [FRAME_BITS-1:0] tx_load_val;
   logic [CNT_W-1:0]      tx_load_cnt;
   logic                  tx_shift;
   logic                  tx_ser;
   logic [FRAME_BITS-1:0] tx_q_unused;
   logic [CNT_W-1:0]      tx_cnt_unused;

   spi_shift40 #(.W(FRAME_BITS), .CW(CNT_W)) u_rx (
      .clk      (clk),
      .rst      (rst),
      .load     (1'b0),
      .load_val ('0),
      .load_cnt ('0),
      .shift    (~cs_b),
      .ser_in   (mosi),
      .cnt_clr  (cs_b),
      .q        (rx_q),
      .ser_out  (rx_ser_unused),
      .cnt      (bit_cnt)
   );

   spi_shift40 #(.W(FRAME_BITS), .CW(CNT_W)) u_tx (
      .clk      (clk),
      .rst      (rst),
      .load     (tx_load),
      .load_val (tx_load_val),
      .load_cnt (tx_load_cnt),
      .shift    (tx_shift),
      .ser_in   (1'b0),
      .cnt_clr  (1'b0),
      .q        (tx_q_unused),
      .ser_out  (tx_ser),
      .cnt      (tx_cnt_unused)
   );

   always_comb begin
      state_d      = state_q;
      sel_d        = sel_q;
      last_frame_d = last_frame_q;
      cfg_reg_d    = cfg_reg_q;
      dac_code_d   = dac_code_q;
      cfg_wr_d     = 1'b0;
      dac_wr_d     = 1'b0;
      frame_err_d  = 1'b0;
      tx_load      = 1'b0;
      tx_load_val  = last_frame_q;
      tx_load_cnt  = '0;
      tx_shift     = 1'b0;
      case (state_q)
         IDLE: begin
            tx_load = 1'b1;
            if (!cs_b) begin
               state_d     = SHIFT;
               sel_d       = spi_sel;
               tx_load_val = last_frame_q << 1;
               tx_load_cnt = CNT_W'(1);
            end
         end
         SHIFT: begin
            if (!cs_b) begin
               tx_shift = 1'b1;
            end else begin
               state_d = IDLE;
               if (bit_cnt != CNT_W'(FRAME_BITS)) begin
                  frame_err_d = 1'b1;
               end else if (sel_q == SEL_CFG) begin
                  cfg_reg_d    = rx_q;
                  cfg_wr_d     = 1'b1;
                  last_frame_d = rx_q;
               end else if (dac_pad_ok(rx_q)) begin
                  dac_code_d   = rx_q[FRAME_BITS-1:DAC_PAD_BITS];
                  dac_wr_d     = 1'b1;
                  last_frame_d = rx_q;
               end else begin
                  frame_err_d = 1'b1;
               end
               // Preload the readback now so a frame starting next edge sees this commit.
               tx_load     = 1'b1;
               tx_load_val = last_frame_d;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         sel_q        <= SEL_CFG;
         last_frame_q <= '0;
         cfg_reg_q    <= CFG_RST;
         dac_code_q   <= '0;
         cfg_wr_q     <= 1'b0;
         dac_wr_q     <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         sel_q        <= sel_d;
         last_frame_q <= last_frame_d;
         cfg_reg_q    <= cfg_reg_d;
         dac_code_q   <= dac_code_d;
         cfg_wr_q     <= cfg_wr_d;
         dac_wr_q     <= dac_wr_d;
         frame_err_q  <= frame_err_d;
      end
   end

   // busy is the registered FSM state bit, so it doubles as the state observation point.
   assign busy      = (state_q == SHIFT);
   assign miso      = tx_ser;
   assign cfg_reg   = cfg_reg_q;
   assign cfg_wr    = cfg_wr_q;
   assign dac_code  = dac_code_q;
   assign dac_wr    = dac_wr_q;
   assign frame_err = frame_err_q;

endmodule
